aes_inv_cipher_iter: RTL and testbench



---
 rtl/aes_inv_cipher_iter_if.sv | 23 ++
 rtl/aes_inv_cipher_iter.sv | 172 +++++++++++++++++
 tb/tb_aes_inv_cipher_iter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/aes_inv_cipher_iter_if.sv
// Block/round-key handshake bundle for the iterative AES inverse cipher.
// slave is the core side; master is the source/sink/key-store side.
interface aes_inv_cipher_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [3:0]   rk_idx;
    logic [127:0] rk;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    modport slave (
        input  in_valid, in_data, rk, out_ready,
        output in_ready, rk_idx, out_valid, out_data, busy
    );

    modport master (
        output in_valid, in_data, rk, out_ready,
        input  in_ready, rk_idx, out_valid, out_data, busy
    );
endinterface

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher: one round per clock, round keys fetched
// from an external store by index (NR down to 0), valid/ready on both sides.
module aes_inv_cipher_iter #(
    parameter int unsigned NR = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    aes_inv_cipher_iter_if.slave  bus
);

    if (NR != 10 && NR != 12 && NR != 14) begin : g_nr_check
        $error("aes_inv_cipher_iter: NR must be 10, 12 or 14");
    end

    localparam logic [3:0] NR_IDX  = 4'(NR);
    localparam logic [3:0] NR_LAST = 4'(NR - 1);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = '0;
        x = a;
        y = b;
        for (int unsigned i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8); 0 maps to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r, x, e;
        r = 8'h01;
        x = a;
        e = 8'hfe;
        for (int unsigned i = 0; i < 8; i++) begin
            if (e[0]) r = gf_mul(r, x);
            x = gf_mul(x, x);
            e = e >> 1;
        end
        return r;
    endfunction

    // Inverse S-box ROM built at elaboration: inverse affine, then field inverse.
    function automatic logic [2047:0] gen_inv_sbox();
        logic [2047:0] t;
        logic [7:0]    s, b;
        t = '0;
        for (int unsigned v = 0; v < 256; v++) begin
            s = v[7:0];
            b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
            t = {gf_inv(b), t[2047:8]};
        end
        return t;
    endfunction

    localparam logic [2047:0] INV_SBOX = gen_inv_sbox();

    function automatic logic [7:0] m09(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ a;
    endfunction
    function automatic logic [7:0] m0b(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
    endfunction
    function automatic logic [7:0] m0d(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
    endfunction
    function automatic logic [7:0] m0e(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {m0e(a0) ^ m0b(a1) ^ m0d(a2) ^ m09(a3),
                m09(a0) ^ m0e(a1) ^ m0b(a2) ^ m0d(a3),
                m0d(a0) ^ m09(a1) ^ m0e(a2) ^ m0b(a3),
                m0b(a0) ^ m0d(a1) ^ m09(a2) ^ m0e(a3)};
    endfunction

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_e;

    state_e       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] st_q, st_d;
    logic [127:0] out_data_q, out_data_d;
    logic         out_valid_q, out_valid_d;
    logic [3:0]   rk_idx;

    logic [127:0] isb;
    logic [127:0] ark;
    logic [127:0] imc;

    // Byte k sits at row k%4, column k/4; row r is rotated right by r.
    for (genvar k = 0; k < 16; k++) begin : g_isb
        localparam int unsigned R   = k % 4;
        localparam int unsigned C   = k / 4;
        localparam int unsigned SRC = R + 4 * ((C + 4 - R) % 4);
        assign isb[127 - 8*k -: 8] = INV_SBOX[{st_q[127 - 8*SRC -: 8], 3'b000} +: 8];
    end

    assign ark = isb ^ bus.rk;

    for (genvar c = 0; c < 4; c++) begin : g_imc
        assign imc[127 - 32*c -: 32] = inv_mix_col(ark[127 - 32*c -: 32]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            st_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            st_q        <= st_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        st_d        = st_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        rk_idx      = '0;
        unique case (state_q)
            IDLE: begin
                rk_idx = NR_IDX;
                if (bus.in_valid) begin
                    st_d    = bus.in_data ^ bus.rk;
                    cnt_d   = NR_LAST;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                rk_idx = cnt_q;
                st_d   = imc;
                if (cnt_q == 4'd1) state_d = FINAL;
                else               cnt_d   = cnt_q - 4'd1;
            end
            FINAL: begin
                out_data_d  = ark;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.rk_idx    = rk_idx;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: FIPS-197 vectors plus random blocks whose
// ciphertext comes from a forward AES-128 model kept here.
module tb_aes_inv_cipher_iter;

    logic clk;
    logic rst_n;

    aes_inv_cipher_iter_if bus ();

    aes_inv_cipher_iter #(.NR(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sbox   [256];
    logic [127:0] rk_tbl [11];

    // Key store: answers the requested index combinationally.
    always_comb bus.rk = (bus.rk_idx <= 4'd10) ? rk_tbl[bus.rk_idx] : '0;

    typedef struct {
        string        name;
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
        return (a << n) | (a >> (8 - n));
    endfunction

    // Forward S-box from the generator-3 walk over GF(2^8).
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sbox[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox[0] = 8'h63;
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = '0;
        x = a;
        y = b;
        while (y != 0) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rcon;
        {w[0], w[1], w[2], w[3]} = key;
        rcon = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]}
                      ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) rk_tbl[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] ref_encrypt(input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   mixb [4];
        logic [7:0]   acc;
        logic [127:0] blk, nxt;
        mixb = '{8'h02, 8'h03, 8'h01, 8'h01};
        blk = pt ^ rk_tbl[0];
        for (int r = 1; r <= 10; r++) begin
            for (int k = 0; k < 16; k++) begin
                s[k] = blk[127:120];
                blk  = blk << 8;
            end
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[row + 4*c] = sbox[s[row + 4*((c + row) % 4)]];
            nxt = '0;
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++) begin
                    acc = '0;
                    if (r == 10) acc = t[row + 4*c];
                    else for (int j = 0; j < 4; j++)
                        acc = acc ^ gmul(t[j + 4*c], mixb[(j - row + 4) % 4]);
                    nxt = {nxt[119:0], acc};
                end
            blk = nxt ^ rk_tbl[r];
        end
        return blk;
    endfunction

    // One block from IDLE back to IDLE; all waits are fixed cycle counts.
    task automatic run_block(input logic [127:0] ct, input logic [127:0] exp_pt,
                             input string nm, input bit noise, input bit early_ready,
                             input int hold);
        check($sformatf("%s in_ready idle", nm), 128'(bus.in_ready), 128'(1));
        check($sformatf("%s rk_idx accept", nm), 128'(bus.rk_idx), 128'(10));
        bus.in_data   = ct;
        bus.in_valid  = 1'b1;
        bus.out_ready = early_ready;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            check($sformatf("%s rk_idx c%0d", nm, j), 128'(bus.rk_idx), 128'(10 - j));
            check($sformatf("%s out_valid c%0d", nm, j), 128'(bus.out_valid), 128'(0));
            check($sformatf("%s busy c%0d", nm, j), 128'(bus.busy), 128'(1));
            check($sformatf("%s in_ready c%0d", nm, j), 128'(bus.in_ready), 128'(0));
            if (noise) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        check($sformatf("%s out_valid", nm), 128'(bus.out_valid), 128'(1));
        check($sformatf("%s out_data", nm), bus.out_data, exp_pt);
        for (int h = 0; h < hold; h++) begin
            bus.out_ready = 1'b0;
            bus.in_valid  = 1'b1;
            bus.in_data   = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            check($sformatf("%s hold%0d out_valid", nm, h), 128'(bus.out_valid), 128'(1));
            check($sformatf("%s hold%0d out_data", nm, h), bus.out_data, exp_pt);
            check($sformatf("%s hold%0d in_ready", nm, h), 128'(bus.in_ready), 128'(0));
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check($sformatf("%s drained out_valid", nm), 128'(bus.out_valid), 128'(0));
        check($sformatf("%s drained in_ready", nm), 128'(bus.in_ready), 128'(1));
        check($sformatf("%s drained busy", nm), 128'(bus.busy), 128'(0));
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t v;
        build_sbox();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        for (int r = 0; r < 11; r++) rk_tbl[r] = '0;

        vecs.push_back('{"c1", 128'h000102030405060708090a0b0c0d0e0f,
                         128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                         128'h00112233445566778899aabbccddeeff});
        vecs.push_back('{"b1", 128'h2b7e151628aed2a6abf7158809cf4f3c,
                         128'h3925841d02dc09fbdc118597196a0b32,
                         128'h3243f6a8885a308d313198a2e0370734});
        for (int i = 0; i < 20; i++) begin
            v.name = $sformatf("rnd%0d", i);
            v.key  = {$urandom, $urandom, $urandom, $urandom};
            v.pt   = {$urandom, $urandom, $urandom, $urandom};
            expand_key(v.key);
            v.ct   = ref_encrypt(v.pt);
            vecs.push_back(v);
        end

        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", 128'(bus.out_valid), 128'(0));
        check("reset busy", 128'(bus.busy), 128'(0));
        check("reset out_data", bus.out_data, 128'(0));
        check("reset rk_idx", 128'(bus.rk_idx), 128'(10));
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("release in_ready", 128'(bus.in_ready), 128'(1));

        foreach (vecs[i]) begin
            expand_key(vecs[i].key);
            run_block(vecs[i].ct, vecs[i].pt, vecs[i].name,
                      (i % 3 == 1), (i % 4 == 2), (i == 0) ? 5 : 0);
        end

        // Reset in the middle of a block, then a clean rerun.
        expand_key(vecs[0].key);
        bus.in_data  = vecs[0].ct;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset out_valid", 128'(bus.out_valid), 128'(0));
        check("midreset busy", 128'(bus.busy), 128'(0));
        check("midreset out_data", bus.out_data, 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_block(vecs[0].ct, vecs[0].pt, "c1 after reset", 1'b0, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
